// File: rtl/pixel_frame_sequencer_pkg.sv
// Shared configuration for the pixel sensor frame path.
// Holds the default array geometry, the frame FSM state type and the derived
// address widths used by the frame sequencer and its readout address generator.
package PixelSensorConfig;

  localparam int unsigned PIXEL_ARRAY_HEIGHT = 128;
  localparam int unsigned PIXEL_ARRAY_WIDTH  = 128;
  localparam int unsigned PIXEL_BITS         = 8;
  localparam int unsigned OUTPUT_BUS_WIDTH   = 8;
  localparam int unsigned ERASE_CYCLES       = 5;
  localparam int unsigned EXPOSE_W           = 16;

  localparam int unsigned GROUPS_PER_ROW = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
  localparam int unsigned ROW_W          = $clog2(PIXEL_ARRAY_HEIGHT);
  localparam int unsigned GRP_W          = $clog2(GROUPS_PER_ROW);

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READ
  } sensor_state_t;

endpackage

// File: rtl/pixel_readout_addr_gen.sv
// Readout address generator for the frame sequencer.
// Walks row/group addresses in raster order (group fastest), advancing only on
// an accepted beat (valid_i && ready_i).
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   valid_i          a beat is being offered at the current address
//   ready_i          output buffer accepts the beat
//   row_o, grp_o     current row / column-group address
//   last_accept_o    the final beat of the frame is accepted this cycle
module pixel_readout_addr_gen import PixelSensorConfig::*; #(
  parameter int unsigned NUM_ROWS = PIXEL_ARRAY_HEIGHT,
  parameter int unsigned NUM_GRPS = GROUPS_PER_ROW,
  parameter int unsigned ROW_BITS = ROW_W,
  parameter int unsigned GRP_BITS = GRP_W
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                valid_i,
  input  logic                ready_i,
  output logic [ROW_BITS-1:0] row_o,
  output logic [GRP_BITS-1:0] grp_o,
  output logic                last_accept_o
);

  logic [ROW_BITS-1:0] row_d, row_q;
  logic [GRP_BITS-1:0] grp_d, grp_q;
  logic                accept;
  logic                row_end;
  logic                grp_end;

  assign accept  = valid_i & ready_i;
  assign grp_end = (grp_q == GRP_BITS'(NUM_GRPS - 1));
  assign row_end = (row_q == ROW_BITS'(NUM_ROWS - 1));

  always_comb begin
    row_d = row_q;
    grp_d = grp_q;
    if (accept) begin
      if (grp_end) begin
        grp_d = '0;
        // Last row wraps to 0 so the next frame starts clean; the FSM ends the frame.
        row_d = row_end ? '0 : row_q + ROW_BITS'(1);
      end else begin
        grp_d = grp_q + GRP_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      row_q <= '0;
      grp_q <= '0;
    end else begin
      row_q <= row_d;
      grp_q <= grp_d;
    end
  end

  assign row_o         = row_q;
  assign grp_o         = grp_q;
  assign last_accept_o = accept & row_end & grp_end;

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Frame-level controller for the pixel array.
// Sequences one capture per accepted start: erase, expose, ADC ramp convert,
// then raster readout in bus-width beats under valid/ready backpressure.
// Ports:
//   clk, reset        main clock, synchronous active-high reset
//   start             frame request, only honoured while idle
//   expose_cycles     exposure length, latched on start (0 behaves as 1)
//   erase/expose/convert  registered, mutually exclusive phase strobes
//   adc_count         ramp value broadcast to the pixel ADCs during convert
//   row_sel, grp_sel  readout address, beat_valid marks it as a live beat
//   beat_ready        output buffer accepts the beat
//   busy              high whenever not idle
//   frame_done        one-cycle pulse after the last beat is accepted
module pixel_frame_sequencer import PixelSensorConfig::*; #(
  parameter int unsigned PIXEL_ARRAY_HEIGHT = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
  parameter int unsigned PIXEL_ARRAY_WIDTH  = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
  parameter int unsigned PIXEL_BITS         = PixelSensorConfig::PIXEL_BITS,
  parameter int unsigned OUTPUT_BUS_WIDTH   = PixelSensorConfig::OUTPUT_BUS_WIDTH,
  parameter int unsigned ERASE_CYCLES       = PixelSensorConfig::ERASE_CYCLES,
  parameter int unsigned EXPOSE_W           = PixelSensorConfig::EXPOSE_W
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 start,
  input  logic [EXPOSE_W-1:0]                                  expose_cycles,
  output logic                                                 erase,
  output logic                                                 expose,
  output logic                                                 convert,
  output logic [PIXEL_BITS-1:0]                                adc_count,
  output logic [$clog2(PIXEL_ARRAY_HEIGHT)-1:0]                row_sel,
  output logic [$clog2(PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH)-1:0] grp_sel,
  output logic                                                 beat_valid,
  input  logic                                                 beat_ready,
  output logic                                                 busy,
  output logic                                                 frame_done
);

  localparam int unsigned NumGrps = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
  localparam int unsigned RowBits = $clog2(PIXEL_ARRAY_HEIGHT);
  localparam int unsigned GrpBits = $clog2(NumGrps);
  localparam int unsigned EraseW  = $clog2(ERASE_CYCLES + 1);
  // One down-counter serves erase and expose, so it must hold the larger of the two.
  localparam int unsigned CntW    = (EXPOSE_W > EraseW) ? EXPOSE_W : EraseW;

  localparam logic [PIXEL_BITS-1:0] AdcMax = '1;

  sensor_state_t         state_q;
  logic [CntW-1:0]       phase_cnt_q;
  logic [EXPOSE_W-1:0]   exp_len_q;
  logic                  erase_q;
  logic                  expose_q;
  logic                  convert_q;
  logic [PIXEL_BITS-1:0] adc_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  last_accept;

  pixel_readout_addr_gen #(
    .NUM_ROWS (PIXEL_ARRAY_HEIGHT),
    .NUM_GRPS (NumGrps),
    .ROW_BITS (RowBits),
    .GRP_BITS (GrpBits)
  ) u_addr_gen (
    .clk_i         (clk),
    .reset_i       (reset),
    .valid_i       (valid_q),
    .ready_i       (beat_ready),
    .row_o         (row_sel),
    .grp_o         (grp_sel),
    .last_accept_o (last_accept)
  );

  // Outputs are registered alongside the state so each phase strobe rises on
  // the same edge the state is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      exp_len_q   <= '0;
      erase_q     <= 1'b0;
      expose_q    <= 1'b0;
      convert_q   <= 1'b0;
      adc_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= ERASE;
            busy_q      <= 1'b1;
            erase_q     <= 1'b1;
            phase_cnt_q <= CntW'(ERASE_CYCLES - 1);
            exp_len_q   <= (expose_cycles == '0) ? EXPOSE_W'(1) : expose_cycles;
          end
        end
        ERASE: begin
          if (phase_cnt_q == '0) begin
            state_q     <= EXPOSE;
            erase_q     <= 1'b0;
            expose_q    <= 1'b1;
            phase_cnt_q <= CntW'(exp_len_q) - CntW'(1);
          end else begin
            phase_cnt_q <= phase_cnt_q - CntW'(1);
          end
        end
        EXPOSE: begin
          if (phase_cnt_q == '0) begin
            state_q   <= CONVERT;
            expose_q  <= 1'b0;
            convert_q <= 1'b1;
            adc_q     <= '0;
          end else begin
            phase_cnt_q <= phase_cnt_q - CntW'(1);
          end
        end
        CONVERT: begin
          // The ramp value itself is the convert-phase counter.
          if (adc_q == AdcMax) begin
            state_q   <= READ;
            convert_q <= 1'b0;
            adc_q     <= '0;
            valid_q   <= 1'b1;
          end else begin
            adc_q <= adc_q + PIXEL_BITS'(1);
          end
        end
        READ: begin
          if (last_accept) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign adc_count  = adc_q;
  assign beat_valid = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
